// File: rtl/tbird_signal_ctrl.sv
// T-bird tail-light front end: switch sync/debounce, step pacing, request arbitration.
// Option: define TBIRD_LANE_CHANGE_EN for multi-sequence lane-change signalling.
module tbird_signal_ctrl #(
  parameter int PRESCALE   = 4,
  parameter int DEBOUNCE   = 3,
  parameter int LC_FLASHES = 3
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_haz,
  input  logic [2:0] l_lights,
  input  logic [2:0] r_lights,
  output logic       step_en,
  output logic       left,
  output logic       right,
  output logic       haz,
  output logic       busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;
  localparam logic [1:0] S_HAZ   = 2'd3;

  logic [PW-1:0] pcnt;
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    filt;
  logic          f_left;
  logic          f_right;
  logic          f_haz;
  logic          both;
  logic          dark;
  logic          seq_ok;
  logic [1:0]    state;
  logic [1:0]    state_nxt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pcnt <= '0;
    end else if (pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign step_en = (pcnt == PMAX);

  assign raw = {sw_haz, sw_right, sw_left};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE straight disagreeing samples.
  for (genvar i = 0; i < 3; i++) begin : g_flt
    logic [DW-1:0] cnt;
    logic          lvl;

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DMAX) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    assign filt[i] = lvl;
  end

  assign f_left  = filt[0];
  assign f_right = filt[1];
  assign f_haz   = filt[2];
  assign both    = f_left & f_right;
  assign dark    = (l_lights == 3'b000) && (r_lights == 3'b000);

`ifdef TBIRD_LANE_CHANGE_EN
  localparam int CW = ($clog2(LC_FLASHES + 1) < 2) ? 2 : $clog2(LC_FLASHES + 1);

  logic [CW-1:0] seq_cnt;
  logic [CW-1:0] seq_cnt_nxt;
  logic          prev_dark;

  // A sequence completes on the first dark step after a lit one.
  always_comb begin
    seq_cnt_nxt = seq_cnt;
    if (dark && !prev_dark && (seq_cnt != '1)) begin
      seq_cnt_nxt = seq_cnt + CW'(1);
    end
  end

  assign seq_ok = (seq_cnt_nxt >= CW'(LC_FLASHES));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      seq_cnt   <= '0;
      prev_dark <= 1'b1;
    end else if (step_en) begin
      prev_dark <= dark;
      seq_cnt   <= (state_nxt != state) ? '0 : seq_cnt_nxt;
    end
  end
`else
  assign seq_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (f_haz || both)   state_nxt = S_HAZ;
        else if (f_left)     state_nxt = S_LEFT;
        else if (f_right)    state_nxt = S_RIGHT;
      end
      S_LEFT: begin
        if (f_haz || both)   state_nxt = S_HAZ;
        else if (!f_left && dark && seq_ok)
          state_nxt = S_IDLE;
      end
      S_RIGHT: begin
        if (f_haz || both)   state_nxt = S_HAZ;
        else if (!f_right && dark && seq_ok)
          state_nxt = S_IDLE;
      end
      S_HAZ: begin
        if (!f_haz && !both && dark)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      left  <= 1'b0;
      right <= 1'b0;
      haz   <= 1'b0;
    end else if (step_en) begin
      state <= state_nxt;
      left  <= (state_nxt == S_LEFT);
      right <= (state_nxt == S_RIGHT);
      haz   <= (state_nxt == S_HAZ);
    end
  end

  assign busy = (state != S_IDLE);

endmodule
